// File: rtl/aes128_inv_key_expansion.sv
// rtl/aes128_inv_key_expansion.sv - AES-128 round keys emitted in reverse order (10 down to 0)
// Expands the cipher key forward to round 10, then walks the schedule backward per handshake.
module aes128_inv_key_expansion (
    input  logic         clk_sys,
    input  logic         rst_sys,
    input  logic         start,
    input  logic [127:0] cipher_key,
    input  logic         rkey_ready,
    output logic         rkey_valid,
    output logic [127:0] round_key_out,
    output logic [3:0]   rkey_round,
    output logic         busy,
    output logic         last_key
);

    typedef enum logic [1:0] {IDLE, EXPAND, OUTPUT} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       state;
    logic [127:0] key_reg;
    logic [3:0]   cnt;

    logic [31:0]  w0, w1, w2, w3, w1p, w2p, w3p;
    logic [31:0]  f0, f1, f2, f3, t;
    logic [31:0]  sbox_in;
    logic [3:0]   rcon_sel;
    logic [127:0] fwd_key, inv_key;

    // One shared SubWord(RotWord()) path: forward uses w3, inverse uses the recovered w3.
    always_comb begin
        w0       = key_reg[127:96];
        w1       = key_reg[95:64];
        w2       = key_reg[63:32];
        w3       = key_reg[31:0];
        w3p      = w3 ^ w2;
        w2p      = w2 ^ w1;
        w1p      = w1 ^ w0;
        sbox_in  = (state == OUTPUT) ? w3p : w3;
        rcon_sel = (state == OUTPUT) ? rkey_round : cnt;
        t        = sub_rot_word(sbox_in) ^ {rcon(rcon_sel), 24'h0};
        f0       = w0 ^ t;
        f1       = w1 ^ f0;
        f2       = w2 ^ f1;
        f3       = w3 ^ f2;
        fwd_key  = {f0, f1, f2, f3};
        inv_key  = {w0 ^ t, w1p, w2p, w3p};
    end

    assign last_key = rkey_valid && (rkey_round == 4'd0);

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state         <= IDLE;
            key_reg       <= '0;
            cnt           <= '0;
            rkey_valid    <= 1'b0;
            round_key_out <= '0;
            rkey_round    <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg <= cipher_key;
                        cnt     <= 4'd1;
                        busy    <= 1'b1;
                        state   <= EXPAND;
                    end
                end
                EXPAND: begin
                    key_reg <= fwd_key;
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd10) begin
                        state         <= OUTPUT;
                        rkey_round    <= 4'd10;
                        rkey_valid    <= 1'b1;
                        round_key_out <= fwd_key;
                    end
                end
                OUTPUT: begin
                    if (rkey_ready) begin
                        if (rkey_round == 4'd0) begin
                            state         <= IDLE;
                            rkey_valid    <= 1'b0;
                            busy          <= 1'b0;
                            round_key_out <= '0;
                            key_reg       <= '0;
                            cnt           <= '0;
                        end else begin
                            key_reg       <= inv_key;
                            round_key_out <= inv_key;
                            rkey_round    <= rkey_round - 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_inv_key_expansion.sv
// tb/tb_aes128_inv_key_expansion.sv - directed-vector bench for the reverse AES-128 key schedule
module tb_aes128_inv_key_expansion;

    logic         clk_sys = 1'b0;
    logic         rst_sys;
    logic         start;
    logic [127:0] cipher_key;
    logic         rkey_ready;
    logic         rkey_valid;
    logic [127:0] round_key_out;
    logic [3:0]   rkey_round;
    logic         busy;
    logic         last_key;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes128_inv_key_expansion dut (
        .clk_sys       (clk_sys),
        .rst_sys       (rst_sys),
        .start         (start),
        .cipher_key    (cipher_key),
        .rkey_ready    (rkey_ready),
        .rkey_valid    (rkey_valid),
        .round_key_out (round_key_out),
        .rkey_round    (rkey_round),
        .busy          (busy),
        .last_key      (last_key)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        rst_sys = 1'b1; start = 1'b0; cipher_key = '0; rkey_ready = 1'b0;
        tick(); tick();
        rst_sys = 1'b0;
        checks++; if (rkey_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rkey_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (rkey_round !== 4'd0) begin errors++; $display("FAIL reset_round got %0d exp 0", rkey_round); end
        checks++; if (round_key_out !== 128'h0) begin errors++; $display("FAIL reset_key got %h exp 0", round_key_out); end
        checks++; if (last_key !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", last_key); end
    endtask

    task automatic test_fips_sequence();
        cipher_key = FIPS_RK[0]; rkey_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fips_busy_c1 got %b exp 1", busy); end
        checks++; if (rkey_valid !== 1'b0) begin errors++; $display("FAIL fips_valid_c1 got %b exp 0", rkey_valid); end
        repeat (9) tick();
        checks++; if (rkey_valid !== 1'b0) begin errors++; $display("FAIL fips_valid_c10 got %b exp 0", rkey_valid); end
        tick();
        for (int r = 10; r >= 0; r--) begin
            checks++; if (rkey_valid !== 1'b1) begin errors++; $display("FAIL fips_valid r%0d got %b exp 1", r, rkey_valid); end
            checks++; if (rkey_round !== 4'(r)) begin errors++; $display("FAIL fips_round got %0d exp %0d", rkey_round, r); end
            checks++; if (round_key_out !== FIPS_RK[r]) begin errors++; $display("FAIL fips_key r%0d got %h exp %h", r, round_key_out, FIPS_RK[r]); end
            checks++; if (last_key !== (r == 0)) begin errors++; $display("FAIL fips_last r%0d got %b exp %b", r, last_key, (r == 0)); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fips_busy_end got %b exp 0", busy); end
        checks++; if (rkey_valid !== 1'b0) begin errors++; $display("FAIL fips_valid_end got %b exp 0", rkey_valid); end
        checks++; if (round_key_out !== 128'h0) begin errors++; $display("FAIL fips_key_end got %h exp 0", round_key_out); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pat;
        int exp_r;
        int stall;
        int cyc;
        pat = 32'b1011_0010_1110_0101_1001_1101_0110_1011;
        exp_r = 10; stall = 0; cyc = 0;
        cipher_key = FIPS_RK[0]; rkey_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        while (exp_r >= 0 && cyc < 200) begin
            checks++; if (rkey_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d got %b exp 1", cyc, rkey_valid); end
            checks++; if (rkey_round !== 4'(exp_r)) begin errors++; $display("FAIL bp_round cyc%0d got %0d exp %0d", cyc, rkey_round, exp_r); end
            checks++; if (round_key_out !== FIPS_RK[exp_r]) begin errors++; $display("FAIL bp_key cyc%0d got %h exp %h", cyc, round_key_out, FIPS_RK[exp_r]); end
            if (exp_r == 10 || exp_r == 0) rkey_ready = (stall >= 5);
            else                           rkey_ready = pat[cyc % 32];
            tick();
            if (rkey_ready) begin exp_r--; stall = 0; end
            else stall++;
            cyc++;
        end
        rkey_ready = 1'b1;
        checks++; if (exp_r != -1) begin errors++; $display("FAIL bp_timeout remaining %0d exp -1", exp_r); end
        checks++; if (rkey_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_end valid %b busy %b exp 0 0", rkey_valid, busy); end
    endtask

    task automatic test_start_busy();
        cipher_key = FIPS_RK[0]; rkey_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; cipher_key = KEY2;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sb_busy got %b exp 1", busy); end
        repeat (6) tick();
        for (int r = 10; r >= 0; r--) begin
            checks++; if (rkey_round !== 4'(r) || round_key_out !== FIPS_RK[r]) begin
                errors++; $display("FAIL sb_key r%0d got %0d %h exp %0d %h", r, rkey_round, round_key_out, r, FIPS_RK[r]);
            end
            if (r == 7) begin start = 1'b1; cipher_key = KEY2; end
            else start = 1'b0;
            tick();
        end
        start = 1'b0;
        checks++; if (busy !== 1'b0 || rkey_valid !== 1'b0) begin errors++; $display("FAIL sb_end busy %b valid %b exp 0 0", busy, rkey_valid); end
    endtask

    task automatic test_reset_mid();
        cipher_key = FIPS_RK[0]; rkey_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_sys = 1'b1;
        tick();
        rst_sys = 1'b0;
        checks++; if (rkey_valid !== 1'b0 || busy !== 1'b0 || rkey_round !== 4'd0 || round_key_out !== 128'h0 || last_key !== 1'b0) begin
            errors++; $display("FAIL rst_expand valid %b busy %b round %0d key %h exp all 0", rkey_valid, busy, rkey_round, round_key_out);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        checks++; if (rkey_valid !== 1'b0) begin errors++; $display("FAIL rst_restart_early got %b exp 0", rkey_valid); end
        tick();
        checks++; if (rkey_valid !== 1'b1 || rkey_round !== 4'd10 || round_key_out !== FIPS_RK[10]) begin
            errors++; $display("FAIL rst_restart_r10 valid %b round %0d key %h exp 1 10 %h", rkey_valid, rkey_round, round_key_out, FIPS_RK[10]);
        end
        repeat (4) tick();
        checks++; if (rkey_round !== 4'd6 || round_key_out !== FIPS_RK[6]) begin
            errors++; $display("FAIL rst_r6 round %0d key %h exp 6 %h", rkey_round, round_key_out, FIPS_RK[6]);
        end
        rst_sys = 1'b1;
        tick();
        rst_sys = 1'b0;
        checks++; if (rkey_valid !== 1'b0 || busy !== 1'b0 || rkey_round !== 4'd0 || round_key_out !== 128'h0 || last_key !== 1'b0) begin
            errors++; $display("FAIL rst_output valid %b busy %b round %0d key %h exp all 0", rkey_valid, busy, rkey_round, round_key_out);
        end
        tick();
        checks++; if (rkey_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_idle valid %b busy %b exp 0 0", rkey_valid, busy); end
    endtask

    task automatic test_back_to_back();
        cipher_key = FIPS_RK[0]; rkey_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        checks++; if (rkey_round !== 4'd0 || last_key !== 1'b1) begin errors++; $display("FAIL b2b_r0 round %0d last %b exp 0 1", rkey_round, last_key); end
        start = 1'b1; cipher_key = KEY2;
        tick();
        checks++; if (busy !== 1'b0 || rkey_valid !== 1'b0) begin errors++; $display("FAIL b2b_ignored busy %b valid %b exp 0 0", busy, rkey_valid); end
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
        repeat (10) tick();
        checks++; if (rkey_valid !== 1'b1 || rkey_round !== 4'd10 || round_key_out !== KEY2_R10) begin
            errors++; $display("FAIL b2b_r10 valid %b round %0d key %h exp 1 10 %h", rkey_valid, rkey_round, round_key_out, KEY2_R10);
        end
        repeat (10) tick();
        checks++; if (round_key_out !== KEY2 || last_key !== 1'b1) begin errors++; $display("FAIL b2b_r0_key got %h last %b exp %h 1", round_key_out, last_key, KEY2); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end busy got %b exp 0", busy); end
    endtask

    task automatic test_zero_key();
        cipher_key = '0; rkey_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        checks++; if (rkey_round !== 4'd10 || round_key_out !== ZERO_R10) begin
            errors++; $display("FAIL zero_r10 round %0d key %h exp 10 %h", rkey_round, round_key_out, ZERO_R10);
        end
        repeat (10) tick();
        checks++; if (rkey_round !== 4'd0 || round_key_out !== 128'h0 || last_key !== 1'b1) begin
            errors++; $display("FAIL zero_r0 round %0d key %h last %b exp 0 0 1", rkey_round, round_key_out, last_key);
        end
        tick();
        checks++; if (rkey_valid !== 1'b0) begin errors++; $display("FAIL zero_end valid got %b exp 0", rkey_valid); end
    endtask

    initial begin
        test_reset();
        test_fips_sequence();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_zero_key();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
